// File: rtl/multicycle_ctrl_pkg.sv
// Shared RISC-V control definitions: FSM states, opcode constants, instruction
// classes, fault codes and the bundled control-output struct.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } state_e;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } cls_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_IMEM    = 2'b10;
    localparam logic [1:0] FC_DMEM    = 2'b11;

    localparam logic [1:0] PCS_PLUS4 = 2'b00;
    localparam logic [1:0] PCS_IMM   = 2'b01;
    localparam logic [1:0] PCS_REG   = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_ctrl_if;
    logic       run;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        input  run, opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               reg_write, mem_to_reg, instr_done, fault, fault_code
    );

    modport slave (
        output run, opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               reg_write, mem_to_reg, instr_done, fault, fault_code
    );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational RV32I major-opcode classifier.
module opcode_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cls_e       o_cls
);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (i_opcode)
            OP_R:      o_cls = CLS_R;
            OP_I:      o_cls = CLS_I;
            OP_LOAD:   o_cls = CLS_LOAD;
            OP_STORE:  o_cls = CLS_STORE;
            OP_BRANCH: o_cls = CLS_BRANCH;
            OP_JAL:    o_cls = CLS_JAL;
            OP_JALR:   o_cls = CLS_JALR;
            OP_LUI:    o_cls = CLS_LUI;
            OP_AUIPC:  o_cls = CLS_AUIPC;
            default:   o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with fetch/data-memory wait timeout and sticky fault.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        r_state;
    state_e        w_state_nxt;
    state_e        w_boundary;
    cls_e          r_cls;
    cls_e          w_cls;
    logic [1:0]    r_fault_code;
    logic [1:0]    w_fault_code_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic          w_ready;
    logic          w_waiting;
    logic          w_expired;
    ctrl_t         w_ctrl;

    opcode_class u_opcode_class (
        .i_opcode (bus.opcode),
        .o_cls    (w_cls)
    );

    assign w_boundary = bus.run ? ST_FETCH : ST_IDLE;
    assign w_ready    = (r_state == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !w_ready;
    // Last permitted wait cycle; a ready arriving in this same cycle still wins.
    assign w_expired  = w_waiting && (r_wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cls        <= CLS_R;
            r_fault_code <= FC_NONE;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_wait_cnt   <= w_waiting ? r_wait_cnt + 1'b1 : '0;
            if (r_state == ST_DECODE)
                r_cls <= w_cls;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fault_code_nxt = r_fault_code;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_boundary;
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_expired) begin
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = FC_IMEM;
                end
            end
            ST_DECODE: begin
                if (w_cls == CLS_ILLEGAL) begin
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = FC_ILLEGAL;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_LOAD, CLS_STORE:           w_state_nxt = ST_MEM;
                    CLS_BRANCH, CLS_JAL, CLS_JALR: w_state_nxt = w_boundary;
                    default:                       w_state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    w_state_nxt = (r_cls == CLS_STORE) ? w_boundary : ST_WB;
                end else if (w_expired) begin
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = FC_DMEM;
                end
            end
            ST_WB:     w_state_nxt = w_boundary;
            ST_FAULT:  w_state_nxt = ST_FAULT;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.imem_req = 1'b1;
                w_ctrl.ir_we    = bus.imem_ready;
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_BRANCH: begin
                        w_ctrl.pc_we      = 1'b1;
                        w_ctrl.pc_sel     = bus.branch_taken ? PCS_IMM : PCS_PLUS4;
                        w_ctrl.instr_done = 1'b1;
                    end
                    CLS_JAL, CLS_JALR: begin
                        w_ctrl.reg_write  = 1'b1;
                        w_ctrl.pc_we      = 1'b1;
                        w_ctrl.pc_sel     = (r_cls == CLS_JAL) ? PCS_IMM : PCS_REG;
                        w_ctrl.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_ctrl.dmem_req = 1'b1;
                w_ctrl.dmem_we  = (r_cls == CLS_STORE);
                if (bus.dmem_ready && (r_cls == CLS_STORE)) begin
                    w_ctrl.pc_we      = 1'b1;
                    w_ctrl.pc_sel     = PCS_PLUS4;
                    w_ctrl.instr_done = 1'b1;
                end
            end
            ST_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = (r_cls == CLS_LOAD);
                w_ctrl.pc_we      = 1'b1;
                w_ctrl.pc_sel     = PCS_PLUS4;
                w_ctrl.instr_done = 1'b1;
            end
            ST_FAULT:  w_ctrl.fault = 1'b1;
            default: ;
        endcase
    end

    assign bus.imem_req   = w_ctrl.imem_req;
    assign bus.dmem_req   = w_ctrl.dmem_req;
    assign bus.dmem_we    = w_ctrl.dmem_we;
    assign bus.ir_we      = w_ctrl.ir_we;
    assign bus.pc_we      = w_ctrl.pc_we;
    assign bus.pc_sel     = w_ctrl.pc_sel;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.instr_done = w_ctrl.instr_done;
    assign bus.fault      = w_ctrl.fault;
    assign bus.fault_code = r_fault_code;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction activity totals compared against a
// transaction-level model of the control sequence.
module tb_multicycle_ctrl;

    localparam int TMO   = 4;
    localparam int NEVER = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cyc;
        logic [7:0] icyc;
        logic [3:0] irwe;
        logic [7:0] dcyc;
        logic [7:0] dwe;
        logic [3:0] pcwe;
        logic [1:0] pcsel;
        logic [3:0] regw;
        logic [3:0] m2r;
        logic [3:0] done;
        logic       flt;
        logic [1:0] fcode;
    } stat_t;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic string fmt(input stat_t s);
        return $sformatf("cyc=%0d ic=%0d irwe=%0d dc=%0d dwe=%0d pcwe=%0d sel=%0d rw=%0d m2r=%0d done=%0d flt=%0d fc=%0d",
                         s.cyc, s.icyc, s.irwe, s.dcyc, s.dwe, s.pcwe, s.pcsel, s.regw, s.m2r, s.done, s.flt, s.fcode);
    endfunction

    // Cycles counted from the first fetch-request cycle up to retire or first fault cycle.
    function automatic stat_t model(input logic [6:0] op, input int iw, input int dw, input logic bt);
        stat_t s;
        int    k;
        int    base;
        s = '0;
        if (iw >= TMO) begin
            s.icyc = 8'(TMO); s.cyc = 8'(TMO + 1); s.flt = 1'b1; s.fcode = 2'b10;
            return s;
        end
        base   = iw + 1;
        s.icyc = 8'(base);
        s.irwe = 4'd1;
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: k = 0;
            7'b0000011: k = 1;
            7'b0100011: k = 2;
            7'b1100011: k = 3;
            7'b1101111: k = 4;
            7'b1100111: k = 5;
            default:    k = 6;
        endcase
        if (k == 6) begin
            s.cyc = 8'(base + 2); s.flt = 1'b1; s.fcode = 2'b01;
            return s;
        end
        if (k == 1 || k == 2) begin
            if (dw >= TMO) begin
                s.dcyc = 8'(TMO);
                if (k == 2) s.dwe = 8'(TMO);
                s.cyc = 8'(base + 2 + TMO + 1); s.flt = 1'b1; s.fcode = 2'b11;
                return s;
            end
            s.dcyc = 8'(dw + 1);
            if (k == 2) s.dwe = 8'(dw + 1);
        end
        s.pcwe  = 4'd1;
        s.done  = 4'd1;
        s.pcsel = (k == 3) ? {1'b0, bt} : (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
        s.regw  = (k == 2 || k == 3) ? 4'd0 : 4'd1;
        s.m2r   = (k == 1) ? 4'd1 : 4'd0;
        case (k)
            0:       s.cyc = 8'(base + 3);
            1:       s.cyc = 8'(base + 2 + dw + 1 + 1);
            2:       s.cyc = 8'(base + 2 + dw + 1);
            default: s.cyc = 8'(base + 2);
        endcase
        return s;
    endfunction

    // Runs one instruction with run=1 and memories that answer after iw/dw wait cycles.
    task automatic drive(input logic [6:0] op, input int iw, input int dw, input logic bt,
                         input bit drop, output stat_t s);
        int ic = 0;
        int dc = 0;
        int n  = 0;
        bit started = 0;
        bit fin = 0;
        s = '0;
        bus.opcode       = op;
        bus.branch_taken = bt;
        bus.run          = 1'b1;
        while (!fin && n < 80) begin
            @(negedge clk);
            n++;
            bus.imem_ready = bus.imem_req && (ic == iw);
            bus.dmem_ready = bus.dmem_req && (dc == dw);
            #1;
            if (bus.imem_req) begin
                ic++;
                if (!started && drop) bus.run = 1'b0;
                started = 1;
            end
            if (started) begin
                s.cyc++;
                if (bus.imem_req)   s.icyc++;
                if (bus.ir_we)      s.irwe++;
                if (bus.dmem_req)   begin s.dcyc++; dc++; end
                if (bus.dmem_we)    s.dwe++;
                if (bus.pc_we)      begin s.pcwe++; s.pcsel = bus.pc_sel; end
                if (bus.reg_write)  s.regw++;
                if (bus.mem_to_reg) s.m2r++;
                if (bus.instr_done) begin s.done++; fin = 1; end
                if (bus.fault)      begin s.flt = 1'b1; s.fcode = bus.fault_code; fin = 1; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.run = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [12:0] outs();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_sel,
                bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.fault, bus.fault_code};
    endfunction

    task automatic test_reset();
        int busy = 0;
        bus.run = 1'b1; bus.opcode = 7'b0110011; bus.branch_taken = 1'b1;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (outs() !== 13'd0) $display("FAIL reset_outs: got %h want 0", outs());
        else n_pass++;
        bus.run = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            if (outs() !== 13'd0) busy++;
        end
        n_chk++;
        if (busy !== 0) $display("FAIL idle_run0: got %0d busy cycles want 0", busy);
        else n_pass++;
    endtask

    task automatic test_add();
        stat_t o, e;
        drive(7'b0110011, 2, 0, 1'b0, 0, o);
        e = model(7'b0110011, 2, 0, 1'b0);
        n_chk++;
        if (o !== e) $display("FAIL add: got %s want %s", fmt(o), fmt(e));
        else n_pass++;
    endtask

    task automatic test_load_store();
        stat_t o, e;
        drive(7'b0000011, 1, 3, 1'b0, 0, o);
        e = model(7'b0000011, 1, 3, 1'b0);
        n_chk++;
        if (o !== e) $display("FAIL load: got %s want %s", fmt(o), fmt(e));
        else n_pass++;
        drive(7'b0100011, 0, 3, 1'b0, 0, o);
        e = model(7'b0100011, 0, 3, 1'b0);
        n_chk++;
        if (o !== e) $display("FAIL store: got %s want %s", fmt(o), fmt(e));
        else n_pass++;
    endtask

    task automatic test_branch_jump();
        stat_t o, e;
        logic [6:0] ops [4] = '{7'b1100011, 7'b1100011, 7'b1101111, 7'b1100111};
        logic       bts [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 1, 0, bts[i], 0, o);
            e = model(ops[i], 1, 0, bts[i]);
            n_chk++;
            if (o !== e) $display("FAIL branch_jump[%0d]: got %s want %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        stat_t o, e;
        int viol = 0;
        do_reset();
        drive(7'b1111111, 1, 0, 1'b0, 0, o);
        e = model(7'b1111111, 1, 0, 1'b0);
        n_chk++;
        if (o !== e) $display("FAIL illegal: got %s want %s", fmt(o), fmt(e));
        else n_pass++;
        bus.run = 1'b1;
        repeat (20) begin
            @(negedge clk);
            bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
            #1;
            if (outs() !== {9'd0, 1'b0, 1'b0, 1'b1, 2'b01}) viol++;
        end
        n_chk++;
        if (viol !== 0) $display("FAIL illegal_sticky: got %0d bad cycles want 0", viol);
        else n_pass++;
    endtask

    task automatic test_timeout();
        stat_t o, e;
        int iws [4] = '{NEVER, 3, 0, 1};
        int dws [4] = '{0, 0, NEVER, TMO - 1};
        logic [6:0] ops [4] = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b0100011};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive(ops[i], iws[i], dws[i], 1'b0, 0, o);
            e = model(ops[i], iws[i], dws[i], 1'b0);
            n_chk++;
            if (o !== e) $display("FAIL timeout[%0d]: got %s want %s", i, fmt(o), fmt(e));
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_random();
        stat_t o, e;
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            int   iw, dw;
            logic bt;
            bit   drop;
            op   = ops[$urandom_range(0, 8)];
            iw   = $urandom_range(0, TMO - 1);
            dw   = $urandom_range(0, TMO - 1);
            bt   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0);
            drive(op, iw, dw, bt, drop, o);
            e = model(op, iw, dw, bt);
            n_chk++;
            if (o !== e) $display("FAIL random[%0d] op=%b: got %s want %s", i, op, fmt(o), fmt(e));
            else n_pass++;
            if (drop) begin
                @(negedge clk);
                bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
                #1;
                n_chk++;
                if (outs() !== 13'd0) $display("FAIL drop_idle[%0d]: got %h want 0", i, outs());
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        int n = 0;
        int busy = 0;
        bus.run = 1'b1; bus.opcode = 7'b0000011; bus.dmem_ready = 1'b0;
        while (!bus.dmem_req && n < 30) begin
            @(negedge clk);
            bus.imem_ready = bus.imem_req;
            #1;
            n++;
        end
        n_chk++;
        if (bus.dmem_req !== 1'b1) $display("FAIL reach_mem: got dmem_req=%b want 1", bus.dmem_req);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.imem_req, bus.dmem_req} !== 2'b00)
            $display("FAIL reset_drop: got req=%b want 00", {bus.imem_req, bus.dmem_req});
        else n_pass++;
        bus.run = 1'b0; bus.imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk); #1;
            if (outs() !== 13'd0) busy++;
        end
        n_chk++;
        if (busy !== 0) $display("FAIL post_reset_idle: got %0d busy cycles want 0", busy);
        else n_pass++;
        bus.run = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if (bus.imem_req !== 1'b1) $display("FAIL first_fetch: got imem_req=%b want 1", bus.imem_req);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_random();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
